adau_spi_master: RTL and testbench



---
 rtl/adau_spi_master.sv | 124 ++++++++++++
 tb/tb_adau_spi_master.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/adau_spi_master.sv
// SPI mode-3 master shifting 32-bit ADAU1761 command words out MSB-first.
// Optional readback capture of the last received byte: ADAU_SPI_READBACK_EN.
module adau_spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] command,
    input  logic        command_valid,
    output logic        spi_ready,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
`ifdef ADAU_SPI_READBACK_EN
    ,
    output logic [7:0]  rdata,
    output logic        rdata_valid
`endif
);

    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       bit_cnt;
    logic [30:0]      tx_sr;   // bit 31 goes straight to spi_mosi at accept

    wire cnt_done = (cnt == CNT_LAST);

`ifdef ADAU_SPI_READBACK_EN
    logic [31:0] rx_sr;
    wire         unused_rx = rx_sr[31];
`else
    wire         unused_miso = spi_miso;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= GAP;
            cnt       <= '0;
            bit_cnt   <= '0;
            tx_sr     <= '0;
            spi_ready <= 1'b0;
            spi_cs_n  <= 1'b1;
            spi_sclk  <= 1'b1;
            spi_mosi  <= 1'b0;
`ifdef ADAU_SPI_READBACK_EN
            rx_sr       <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
`endif
        end else begin
            cnt <= cnt_done ? '0 : cnt + 1'b1;
`ifdef ADAU_SPI_READBACK_EN
            rdata_valid <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (command_valid) begin
                        tx_sr     <= command[30:0];
                        spi_mosi  <= command[31];
                        spi_cs_n  <= 1'b0;
                        spi_ready <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_done) begin
                        spi_sclk <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_done) begin
                        if (!spi_sclk) begin
                            spi_sclk <= 1'b1;
`ifdef ADAU_SPI_READBACK_EN
                            rx_sr    <= {rx_sr[30:0], spi_miso};
`endif
                        end else if (bit_cnt == 5'd31) begin
                            bit_cnt <= '0;
                            state   <= HOLD;
                        end else begin
                            spi_sclk <= 1'b0;
                            bit_cnt  <= bit_cnt + 5'd1;
                            spi_mosi <= tx_sr[30];
                            tx_sr    <= {tx_sr[29:0], 1'b0};
                        end
                    end
                end
                HOLD: begin
                    if (cnt_done) begin
                        spi_cs_n <= 1'b1;
`ifdef ADAU_SPI_READBACK_EN
                        rdata       <= rx_sr[7:0];
                        rdata_valid <= 1'b1;
`endif
                        // The deselect edge itself is the first gap cycle.
                        if (CLK_DIV == 1) begin
                            state     <= IDLE;
                            spi_ready <= 1'b1;
                        end else begin
                            state <= GAP;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                GAP: begin
                    if (cnt_done) begin
                        state     <= IDLE;
                        spi_ready <= 1'b1;
                    end
                end
                default: state <= GAP;
            endcase
        end
    end

endmodule

// File: tb/tb_adau_spi_master.sv
// Bench for adau_spi_master: CLK_DIV=4 and CLK_DIV=1 instances, SPI slave model.
module tb_adau_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst4, rst1, sel, valid, miso;
    logic [31:0] command;
    logic        rdy4, cs4, sck4, mo4, rdy1, cs1, sck1, mo1;
    int          checks = 0;
    int          errors = 0;

`ifdef ADAU_SPI_READBACK_EN
    logic [7:0] rd4, rd1;
    logic       rv4, rv1;
    wire [7:0]  rdata  = sel ? rd1 : rd4;
    wire        rvalid = sel ? rv1 : rv4;
`endif

    adau_spi_master #(.CLK_DIV(4)) u4 (
        .clk(clk), .reset_n(rst4), .command(command), .command_valid(valid && !sel),
        .spi_ready(rdy4), .spi_cs_n(cs4), .spi_sclk(sck4), .spi_mosi(mo4), .spi_miso(miso)
`ifdef ADAU_SPI_READBACK_EN
        , .rdata(rd4), .rdata_valid(rv4)
`endif
    );

    adau_spi_master #(.CLK_DIV(1)) u1 (
        .clk(clk), .reset_n(rst1), .command(command), .command_valid(valid && sel),
        .spi_ready(rdy1), .spi_cs_n(cs1), .spi_sclk(sck1), .spi_mosi(mo1), .spi_miso(miso)
`ifdef ADAU_SPI_READBACK_EN
        , .rdata(rd1), .rdata_valid(rv1)
`endif
    );

    wire ready = sel ? rdy1 : rdy4;
    wire cs    = sel ? cs1  : cs4;
    wire sclk  = sel ? sck1 : sck4;
    wire mosi  = sel ? mo1  : mo4;

    typedef struct {
        logic [31:0] cmd;
        bit          use1;
        bit          toggle;
        bit          keep;
        int          exp_low;
        int          exp_rise;
        int          exp_ready;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // One transfer observed at each negedge; j counts clk edges after the accept edge.
    task automatic run_word(input logic [31:0] cmd, input logic [31:0] nxt, input bit use1,
                            input bit chained, input bit toggle, input bit keep,
                            input int exp_low, input int exp_rise, input int exp_ready,
                            input logic [31:0] pat);
        int d, rises, low, first_rise, ready_j, tail, wait_n, pulses;
        logic [31:0] cap;
        logic prev_sclk;
        d = use1 ? 1 : 4;
        rises = 0; low = 0; first_rise = -1; ready_j = -1; tail = 0; pulses = 0;
        cap = '0; prev_sclk = 1'b1;
        if (!chained) begin
            sel = use1;
            @(negedge clk);
            wait_n = 0;
            while (!ready && wait_n < 2000) begin
                @(negedge clk);
                wait_n++;
            end
            if (!ready) begin
                chk("ready_wait_timeout", 32'd0, 32'd1);
                return;
            end
            command = cmd;
            valid   = 1'b1;
        end
        miso = pat[31];
        @(posedge clk);
        for (int j = 0; j < 67 * d + 20; j++) begin
            @(negedge clk);
            if (j == 0) begin
                chk("ready_low_after_accept", {31'd0, ready}, 32'd0);
                chk("cs_low_after_accept", {31'd0, cs}, 32'd0);
                if (!keep) valid = 1'b0;
            end
            if (toggle && j == 10) command = ~cmd;
            if (!cs) low++;
            if (!cs && sclk && !prev_sclk) begin
                if (rises == 0) first_rise = j;
                cap = {cap[30:0], mosi};
                rises++;
            end
            if (cs && low > 0) tail++;
            if (!sclk && rises < 32) miso = pat[31 - rises];
`ifdef ADAU_SPI_READBACK_EN
            if (rvalid) begin
                pulses++;
                chk("rdata_valid_cycle", j, exp_low);
                chk("rdata", {24'd0, rdata}, {24'd0, pat[7:0]});
            end
`endif
            prev_sclk = sclk;
            if (ready) begin
                ready_j = j;
                break;
            end
        end
        chk("captured_word", cap, cmd);
        chk("sclk_rises", rises, 32);
        chk("cs_low_cycles", low, exp_low);
        chk("first_rise", first_rise, exp_rise);
        chk("ready_return", ready_j, exp_ready);
        chk("cs_gap", tail, d);
`ifdef ADAU_SPI_READBACK_EN
        chk("rdata_valid_pulses", pulses, 1);
`endif
        if (keep) command = nxt;
    endtask

    task automatic check_release(input int d, input string name);
        for (int k = 1; k <= d; k++) begin
            @(negedge clk);
            if (k == d - 1) chk({name, "_ready_early"}, {31'd0, ready}, 32'd0);
            if (k == d)     chk({name, "_ready_rise"},  {31'd0, ready}, 32'd1);
            chk({name, "_sclk_idle"}, {31'd0, sclk}, 32'd1);
        end
    endtask

    vec_t vecs[4];

    initial begin
        logic [31:0] pat;
        int          rises, bad_sclk, bad_cs, d;
        logic        prev;

        vecs[0] = '{32'h01400001, 1'b0, 1'b0, 1'b1, 264, 8, 267};
        vecs[1] = '{32'h0140F9FF, 1'b0, 1'b1, 1'b0, 264, 8, 267};
        vecs[2] = '{32'h00000000, 1'b1, 1'b0, 1'b0, 66, 2, 66};
        vecs[3] = '{32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 66, 2, 66};

        rst4 = 1'b0; rst1 = 1'b0; sel = 1'b0; valid = 1'b0; miso = 1'b0; command = '0;
        repeat (5) @(negedge clk);
        chk("rst_cs4", {31'd0, cs4}, 32'd1);
        chk("rst_sclk4", {31'd0, sck4}, 32'd1);
        chk("rst_mosi4", {31'd0, mo4}, 32'd0);
        chk("rst_ready4", {31'd0, rdy4}, 32'd0);
        chk("rst_cs1", {31'd0, cs1}, 32'd1);
        chk("rst_ready1", {31'd0, rdy1}, 32'd0);
`ifdef ADAU_SPI_READBACK_EN
        chk("rst_rdata", {23'd0, rv4, rd4}, 32'd0);
`endif
        rst4 = 1'b1; rst1 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) chk("release_ready1", {31'd0, rdy1}, 32'd1);
            if (k == 3) chk("release_ready4_early", {31'd0, rdy4}, 32'd0);
            if (k == 4) chk("release_ready4", {31'd0, rdy4}, 32'd1);
        end

        // Table: back-to-back pair on CLK_DIV=4, then CLK_DIV=1 words.
        for (int i = 0; i < 4; i++) begin
            pat = {$urandom_range(0, 32'hFFFF), 16'h00A5};
            run_word(vecs[i].cmd, (i == 0) ? vecs[1].cmd : 32'd0, vecs[i].use1,
                     (i == 1), vecs[i].toggle, vecs[i].keep,
                     vecs[i].exp_low, vecs[i].exp_rise, vecs[i].exp_ready, pat);
        end

        // Random words against the timing model derived from CLK_DIV.
        for (int i = 0; i < 6; i++) begin
            d = ($urandom_range(0, 1) == 1) ? 1 : 4;
            pat = $urandom;
            run_word($urandom, 32'd0, (d == 1), 1'b0, $urandom_range(0, 1) == 1, 1'b0,
                     66 * d, 2 * d, 67 * d - 1, pat);
        end

        // Abort after 10 bits on the CLK_DIV=4 instance.
        sel = 1'b0;
        @(negedge clk);
        command = 32'hDEADBEEF; valid = 1'b1;
        @(posedge clk);
        rises = 0; prev = 1'b1;
        for (int j = 0; j < 200 && rises < 10; j++) begin
            @(negedge clk);
            if (!cs && sclk && !prev) rises++;
            prev = sclk;
        end
        chk("abort_reached_10_bits", rises, 10);
        valid = 1'b0; rst4 = 1'b0;
        @(negedge clk);
        chk("abort_cs", {31'd0, cs4}, 32'd1);
        chk("abort_sclk", {31'd0, sck4}, 32'd1);
        chk("abort_ready", {31'd0, rdy4}, 32'd0);
        bad_sclk = 0;
        repeat (3) begin
            @(negedge clk);
            if (!sck4 || !cs4) bad_sclk++;
        end
        rst4 = 1'b1;
        check_release(4, "abort");
        bad_cs = 0;
        repeat (20) begin
            @(negedge clk);
            if (!cs4 || !sck4) bad_cs++;
        end
        chk("abort_sclk_quiet", bad_sclk, 0);
        chk("abort_no_retry", bad_cs, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
